// File: rtl/mood_pkg.sv
// Shared definitions for the mood command scheduler.
//   - target_e : which saturating counter a request addresses
//   - op_e     : what the request asks that counter to do
//   - state_e  : scheduler FSM states
//   - cmd_t    : the nine one-bit counter command pulses
//   - decode_cmd / cmd_valid : map a (target, op) pair onto cmd_t
package mood_pkg;

    typedef enum logic [1:0] {
        TGT_ENERGY   = 2'd0,
        TGT_STRESS   = 2'd1,
        TGT_PLEASURE = 2'd2,
        TGT_INVALID  = 2'd3
    } target_e;

    typedef enum logic [1:0] {
        OP_INC     = 2'd0,
        OP_DEC     = 2'd1,
        OP_SET     = 2'd2,
        OP_INVALID = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ARB     = 2'd0,
        DECAY_A = 2'd1,
        DECAY_B = 2'd2
    } state_e;

    typedef struct packed {
        logic en_inc;
        logic en_dec;
        logic en_set;
        logic st_inc;
        logic st_dec;
        logic st_set;
        logic pl_inc;
        logic pl_dec;
        logic pl_set;
    } cmd_t;

    // A request is only turned into a counter command when both fields are legal.
    function automatic logic cmd_valid(input logic [1:0] target, input logic [1:0] op);
        return (target != TGT_INVALID) && (op != OP_INVALID);
    endfunction

    // Exactly one bit of the result is set for a legal pair; all zero otherwise.
    function automatic cmd_t decode_cmd(input logic [1:0] target, input logic [1:0] op);
        cmd_t    c;
        target_e t;
        op_e     o;
        c = '0;
        t = target_e'(target);
        o = op_e'(op);
        case (t)
            TGT_ENERGY: begin
                case (o)
                    OP_INC:  c.en_inc = 1'b1;
                    OP_DEC:  c.en_dec = 1'b1;
                    OP_SET:  c.en_set = 1'b1;
                    default: c = '0;
                endcase
            end
            TGT_STRESS: begin
                case (o)
                    OP_INC:  c.st_inc = 1'b1;
                    OP_DEC:  c.st_dec = 1'b1;
                    OP_SET:  c.st_set = 1'b1;
                    default: c = '0;
                endcase
            end
            TGT_PLEASURE: begin
                case (o)
                    OP_INC:  c.pl_inc = 1'b1;
                    OP_DEC:  c.pl_dec = 1'b1;
                    OP_SET:  c.pl_set = 1'b1;
                    default: c = '0;
                endcase
            end
            default: c = '0;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mood_cmd_scheduler_if.sv
// Request/acknowledge bundle between the requesters and the scheduler.
//   req        : per-requester request level
//   req_target : 2 bits per requester, target counter code
//   req_op     : 2 bits per requester, operation code
//   ack        : one-cycle acknowledge pulse, one-hot or zero
// master = requester side, slave = scheduler side.
interface mood_cmd_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [2*NUM_REQ-1:0] req_target;
    logic [2*NUM_REQ-1:0] req_op;
    logic [NUM_REQ-1:0]   ack;

    modport master (
        output req,
        output req_target,
        output req_op,
        input  ack
    );

    modport slave (
        input  req,
        input  req_target,
        input  req_op,
        output ack
    );
endinterface

// File: rtl/mood_cmd_scheduler_rr_arbiter.sv
// Combinational masked round-robin picker.
//   req   : request vector
//   mask  : requesters that must not be granted this cycle
//   ptr   : index of the last winner; search starts just after it
//   grant : one-hot winner (zero when nothing eligible)
//   valid : a winner exists
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] mask,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic               valid
);

    logic [NUM_REQ-1:0] eligible;

    assign eligible = req & ~mask;

    // Walk the requesters circularly starting one past the pointer; the first hit wins.
    always_comb begin
        int idx;
        grant = '0;
        valid = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!valid && eligible[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mood_cmd_scheduler.sv
// Single command port into the energy/stress/pleasure saturating counters.
// Arbitrates requester commands round-robin and inserts a periodic two-step
// decay (stress down, then energy up/down depending on sleep).
// All outputs are registered: a request sampled on one edge appears as
// ack + command during the following cycle.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   req_bus         : request/ack bundle (slave side)
//   asleep          : selects energy decay direction
//   en_*/st_*/pl_*  : counter command pulses, at most one high per cycle
//   cmd_err         : pulse, the acked request had an invalid target or op
//   decay_overrun   : sticky, a decay tick arrived while one was pending
//   busy            : high while the decay sequence is being issued
module mood_cmd_scheduler
    import mood_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int DECAY_PERIOD = 256,
    parameter int CNT_W        = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mood_cmd_scheduler_if.slave  req_bus,
    input  logic                 asleep,
    output logic                 en_inc,
    output logic                 en_dec,
    output logic                 en_set,
    output logic                 st_inc,
    output logic                 st_dec,
    output logic                 st_set,
    output logic                 pl_inc,
    output logic                 pl_dec,
    output logic                 pl_set,
    output logic                 cmd_err,
    output logic                 decay_overrun,
    output logic                 busy
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   prescaler_q;
    logic               decay_pending_q, decay_pending_d;
    logic               decay_overrun_q;
    logic [NUM_REQ-1:0] ack_q, ack_d;
    cmd_t               cmd_q, cmd_d;
    logic               cmd_err_q, cmd_err_d;
    logic               busy_q;

    logic [NUM_REQ-1:0] grant;
    logic               grant_valid;
    logic [PTR_W-1:0]   grant_idx;
    logic [1:0]         sel_target;
    logic [1:0]         sel_op;
    logic               wrap;
    logic               entering_decay;
    logic               overrun_hit;

    // Requesters whose ack is high this cycle are still holding the request
    // they were just granted, so they are masked out to avoid a double grant.
    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_arbiter (
        .req   (req_bus.req),
        .mask  (ack_q),
        .ptr   (rr_ptr_q),
        .grant (grant),
        .valid (grant_valid)
    );

    // Convert the one-hot grant into an index and pick that requester's fields.
    always_comb begin
        grant_idx  = '0;
        sel_target = 2'd0;
        sel_op     = 2'd0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx  = PTR_W'(i);
                sel_target = req_bus.req_target[2*i +: 2];
                sel_op     = req_bus.req_op[2*i +: 2];
            end
        end
    end

    assign wrap = (prescaler_q == CNT_W'(DECAY_PERIOD - 1));

    // Next-state and next-output decision. The edge that ends DECAY_B already
    // arbitrates, so a request waiting behind the decay is acked immediately
    // after it. DECAY_A always proceeds to DECAY_B: a started decay finishes.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        ack_d          = '0;
        cmd_d          = '0;
        cmd_err_d      = 1'b0;
        entering_decay = 1'b0;
        case (state_q)
            DECAY_A: begin
                state_d      = DECAY_B;
                cmd_d.en_inc = asleep;
                cmd_d.en_dec = ~asleep;
            end
            ARB, DECAY_B: begin
                state_d = ARB;
                if (grant_valid) begin
                    ack_d    = grant;
                    rr_ptr_d = grant_idx;
                    if (cmd_valid(sel_target, sel_op)) begin
                        cmd_d = decode_cmd(sel_target, sel_op);
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end else if (decay_pending_q) begin
                    state_d        = DECAY_A;
                    cmd_d.st_dec   = 1'b1;
                    entering_decay = 1'b1;
                end
            end
            default: begin
                state_d = ARB;
            end
        endcase
    end

    // Pending is cleared on decay entry before the new tick is considered, so a
    // tick landing on the entry edge is queued without counting as an overrun.
    always_comb begin
        overrun_hit     = wrap && decay_pending_q && !entering_decay;
        decay_pending_d = (decay_pending_q && !entering_decay) || wrap;
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q         <= ARB;
            rr_ptr_q        <= PTR_W'(NUM_REQ - 1);
            prescaler_q     <= '0;
            decay_pending_q <= 1'b0;
            decay_overrun_q <= 1'b0;
            ack_q           <= '0;
            cmd_q           <= '0;
            cmd_err_q       <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            prescaler_q     <= wrap ? '0 : prescaler_q + CNT_W'(1);
            decay_pending_q <= decay_pending_d;
            decay_overrun_q <= decay_overrun_q | overrun_hit;
            ack_q           <= ack_d;
            cmd_q           <= cmd_d;
            cmd_err_q       <= cmd_err_d;
            busy_q          <= (state_d != ARB);
        end
    end

    assign req_bus.ack   = ack_q;
    assign en_inc        = cmd_q.en_inc;
    assign en_dec        = cmd_q.en_dec;
    assign en_set        = cmd_q.en_set;
    assign st_inc        = cmd_q.st_inc;
    assign st_dec        = cmd_q.st_dec;
    assign st_set        = cmd_q.st_set;
    assign pl_inc        = cmd_q.pl_inc;
    assign pl_dec        = cmd_q.pl_dec;
    assign pl_set        = cmd_q.pl_set;
    assign cmd_err       = cmd_err_q;
    assign decay_overrun = decay_overrun_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_mood_cmd_scheduler.sv
// Self-checking bench for mood_cmd_scheduler: directed scenarios plus a
// randomized phase, all compared every cycle against a cycle-counting
// behavioural model of the scheduling rules.
module tb_mood_cmd_scheduler;

    localparam int NUM_REQ      = 4;
    localparam int DECAY_PERIOD = 8;
    localparam int CNT_W        = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic asleep;
    logic en_inc, en_dec, en_set, st_inc, st_dec, st_set, pl_inc, pl_dec, pl_set;
    logic cmd_err, decay_overrun, busy;
    logic [8:0] cmd_vec;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Requester-side stimulus state: mode 0 one-shot, 1 permanent, 2 random.
    logic [NUM_REQ-1:0] req_v;
    logic [1:0]         tgt_v    [NUM_REQ];
    logic [1:0]         op_v     [NUM_REQ];
    int                 mode     [NUM_REQ];
    bit                 seen_ack [NUM_REQ];

    // Reference model state.
    int                 m_ptr;
    int                 m_cyc;
    int                 m_step;
    bit                 m_pending;
    bit                 m_overrun;
    logic [NUM_REQ-1:0] exp_ack;
    logic [8:0]         exp_cmd;
    bit                 exp_err;
    bit                 exp_busy;

    always #5 clk = ~clk;

    mood_cmd_scheduler_if #(.NUM_REQ(NUM_REQ)) req_bus ();

    mood_cmd_scheduler #(
        .NUM_REQ      (NUM_REQ),
        .DECAY_PERIOD (DECAY_PERIOD),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_bus       (req_bus.slave),
        .asleep        (asleep),
        .en_inc        (en_inc),
        .en_dec        (en_dec),
        .en_set        (en_set),
        .st_inc        (st_inc),
        .st_dec        (st_dec),
        .st_set        (st_set),
        .pl_inc        (pl_inc),
        .pl_dec        (pl_dec),
        .pl_set        (pl_set),
        .cmd_err       (cmd_err),
        .decay_overrun (decay_overrun),
        .busy          (busy)
    );

    assign cmd_vec = {en_inc, en_dec, en_set, st_inc, st_dec, st_set, pl_inc, pl_dec, pl_set};

    // One clock of the scheduling rules: a started decay always finishes,
    // otherwise round-robin grant of unmasked requests beats a pending decay.
    task automatic modelStep();
        logic [NUM_REQ-1:0] last_ack;
        int g;
        int idx;
        int t;
        int o;
        last_ack = exp_ack;
        g        = -1;
        exp_ack  = '0;
        exp_cmd  = '0;
        exp_err  = 1'b0;
        m_cyc    = m_cyc + 1;
        if (m_step == 1) begin
            exp_cmd = asleep ? 9'b100000000 : 9'b010000000;
            m_step  = 2;
        end else begin
            for (int k = 1; k <= NUM_REQ; k++) begin
                idx = (m_ptr + k) % NUM_REQ;
                if (g < 0 && req_bus.req[idx] && !last_ack[idx]) g = idx;
            end
            if (g >= 0) begin
                m_ptr      = g;
                exp_ack[g] = 1'b1;
                t = int'(req_bus.req_target[2*g +: 2]);
                o = int'(req_bus.req_op[2*g +: 2]);
                if (t == 3 || o == 3) exp_err = 1'b1;
                else                  exp_cmd = 9'b100000000 >> (t * 3 + o);
                m_step = 0;
            end else if (m_pending) begin
                m_pending = 1'b0;
                exp_cmd   = 9'b000010000;
                m_step    = 1;
            end else begin
                m_step = 0;
            end
        end
        if (m_cyc % DECAY_PERIOD == 0) begin
            if (m_pending) m_overrun = 1'b1;
            else           m_pending = 1'b1;
        end
        exp_busy = (m_step != 0);
    endtask

    // Model follows the DUT's reset asynchronously and steps on each rising edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ptr     = NUM_REQ - 1;
            m_cyc     = 0;
            m_step    = 0;
            m_pending = 1'b0;
            m_overrun = 1'b0;
            exp_ack   = '0;
            exp_cmd   = '0;
            exp_err   = 1'b0;
            exp_busy  = 1'b0;
        end else begin
            modelStep();
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks = checks + 1;
        if (actual !== expected) begin
            errors = errors + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
        end
    endtask

    task automatic driveBus();
        req_bus.req = req_v;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_bus.req_target[2*i +: 2] = tgt_v[i];
            req_bus.req_op[2*i +: 2]     = op_v[i];
        end
    endtask

    task automatic setReq(input int i, input logic r, input logic [1:0] t, input logic [1:0] o, input int m);
        req_v[i] = r;
        tgt_v[i] = t;
        op_v[i]  = o;
        mode[i]  = m;
        driveBus();
    endtask

    // Requesters hold a command through the edge that ends its ack cycle and
    // only then drop or replace it.
    task automatic applyStimulus();
        for (int i = 0; i < NUM_REQ; i++) begin
            if (seen_ack[i]) begin
                seen_ack[i] = 1'b0;
                if (mode[i] == 0) begin
                    req_v[i] = 1'b0;
                end else if (mode[i] == 2) begin
                    if ($urandom_range(0, 1) == 0) begin
                        req_v[i] = 1'b0;
                    end else begin
                        tgt_v[i] = 2'($urandom_range(0, 3));
                        op_v[i]  = 2'($urandom_range(0, 3));
                    end
                end
            end else if (mode[i] == 2 && !req_v[i] && $urandom_range(0, 3) == 0) begin
                req_v[i] = 1'b1;
                tgt_v[i] = 2'($urandom_range(0, 3));
                op_v[i]  = 2'($urandom_range(0, 3));
            end
            if (exp_ack[i]) seen_ack[i] = 1'b1;
        end
        driveBus();
    endtask

    task automatic checkCycle();
        checkOutput("ack", 32'(req_bus.ack), 32'(exp_ack));
        checkOutput("cmd", 32'(cmd_vec), 32'(exp_cmd));
        checkOutput("cmd_err", 32'(cmd_err), 32'(exp_err));
        checkOutput("busy", 32'(busy), 32'(exp_busy));
        checkOutput("overrun", 32'(decay_overrun), 32'(m_overrun));
        checkOutput("cmd_onehot", 32'($countones(cmd_vec) <= 1), 32'd1);
    endtask

    task automatic step();
        @(negedge clk);
        cyc = cyc + 1;
        checkCycle();
        applyStimulus();
    endtask

    task automatic clearRequesters();
        req_v = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            tgt_v[i]    = 2'd0;
            op_v[i]     = 2'd0;
            mode[i]     = 0;
            seen_ack[i] = 1'b0;
        end
        driveBus();
    endtask

    task automatic doReset();
        @(negedge clk);
        rst    = 1'b1;
        asleep = 1'b0;
        clearRequesters();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        int first_st;
        int first_en;
        int inc_count;
        asleep = 1'b0;
        clearRequesters();

        // Idle: decay sequence at cycles 9/10 after release, repeating every 8.
        doReset();
        first_st = -1;
        first_en = -1;
        for (int n = 0; n < 20; n++) begin
            step();
            if (cyc == 1) checkOutput("reset_ack", 32'(req_bus.ack), 32'd0);
            if (st_dec && first_st < 0) first_st = cyc;
            if (en_dec && first_en < 0) first_en = cyc;
            if (cyc == 9 || cyc == 10) checkOutput("busy_decay", 32'(busy), 32'd1);
            if (cyc == 17) checkOutput("st_dec_repeat", 32'(st_dec), 32'd1);
            if (cyc == 18) checkOutput("en_dec_repeat", 32'(en_dec), 32'd1);
        end
        checkOutput("first_st_dec", 32'(first_st), 32'd9);
        checkOutput("first_en_dec", 32'(first_en), 32'd10);

        // Two one-shot stress increments: ack 0 then 2 on consecutive cycles.
        doReset();
        setReq(0, 1'b1, 2'd1, 2'd0, 0);
        setReq(2, 1'b1, 2'd1, 2'd0, 0);
        inc_count = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            if (cyc == 1) checkOutput("ack_first", 32'(req_bus.ack), 32'h1);
            if (cyc == 2) checkOutput("ack_second", 32'(req_bus.ack), 32'h4);
            if (st_inc) inc_count = inc_count + 1;
        end
        checkOutput("st_inc_count", 32'(inc_count), 32'd2);

        // All four held: strict rotation, decay starved, overrun after 2nd wrap.
        doReset();
        setReq(0, 1'b1, 2'd0, 2'd0, 1);
        setReq(1, 1'b1, 2'd1, 2'd1, 1);
        setReq(2, 1'b1, 2'd2, 2'd2, 1);
        setReq(3, 1'b1, 2'd0, 2'd2, 1);
        for (int n = 0; n < 20; n++) begin
            step();
            if (cyc == 1) checkOutput("rot_0", 32'(req_bus.ack), 32'h1);
            if (cyc == 2) checkOutput("rot_1", 32'(req_bus.ack), 32'h2);
            if (cyc == 3) checkOutput("rot_2", 32'(req_bus.ack), 32'h4);
            if (cyc == 4) checkOutput("rot_3", 32'(req_bus.ack), 32'h8);
            if (cyc == 5) checkOutput("rot_wrap", 32'(req_bus.ack), 32'h1);
            if (cyc == 9) checkOutput("decay_starved", 32'(busy), 32'd0);
            if (cyc == 15) checkOutput("overrun_before", 32'(decay_overrun), 32'd0);
            if (cyc == 16) checkOutput("overrun_after", 32'(decay_overrun), 32'd1);
        end

        // Invalid target: ack + cmd_err, no counter command.
        doReset();
        setReq(1, 1'b1, 2'd3, 2'd0, 0);
        step();
        checkOutput("err_ack", 32'(req_bus.ack), 32'h2);
        checkOutput("err_flag", 32'(cmd_err), 32'd1);
        checkOutput("err_no_cmd", 32'(cmd_vec), 32'd0);
        repeat (3) step();

        // Asleep: DECAY_B increments energy; request raised in DECAY_A waits.
        doReset();
        asleep = 1'b1;
        while (cyc < 9) step();
        checkOutput("sleep_st_dec", 32'(st_dec), 32'd1);
        setReq(0, 1'b1, 2'd2, 2'd0, 0);
        step();
        checkOutput("sleep_en_inc", 32'(en_inc), 32'd1);
        checkOutput("sleep_no_en_dec", 32'(en_dec), 32'd0);
        step();
        checkOutput("after_decay_ack", 32'(req_bus.ack), 32'h1);
        repeat (3) step();

        // Asynchronous reset while in DECAY_A abandons the sequence.
        doReset();
        while (cyc < 9) step();
        checkOutput("pre_rst_st_dec", 32'(st_dec), 32'd1);
        #2 rst = 1'b1;
        #1;
        checkOutput("rst_cmd", 32'(cmd_vec), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_ack", 32'(req_bus.ack), 32'd0);
        @(negedge clk);
        checkOutput("rst_no_en_dec", 32'(en_dec), 32'd0);
        rst = 1'b0;
        cyc = 0;
        setReq(0, 1'b1, 2'd0, 2'd1, 1);
        setReq(1, 1'b1, 2'd0, 2'd1, 1);
        setReq(2, 1'b1, 2'd0, 2'd1, 1);
        setReq(3, 1'b1, 2'd0, 2'd1, 1);
        step();
        checkOutput("post_rst_grant", 32'(req_bus.ack), 32'h1);
        repeat (4) step();

        // Randomized traffic against the model.
        doReset();
        for (int i = 0; i < NUM_REQ; i++) mode[i] = 2;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) asleep = ~asleep;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mood_cmd_scheduler.md
Name: mood_cmd_scheduler

Overview:
- Single command port into the shared energy/stress/pleasure saturating counters.
- Arbitrates inc/dec/set requests from NUM_REQ requesters (sleep controller, stimulus regulators, host) with round-robin fairness.
- Inserts a periodic two-step decay sequence.
- Guarantees at most one counter command per cycle, so no counter sees conflicting inc and dec.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DECAY_PERIOD, 256, cycles between decay events (>=4).
- CNT_W, 8, width of the decay prescaler (2^CNT_W >= DECAY_PERIOD).

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- req  in  NUM_REQ  per-requester request level.
- req_target  in  2*NUM_REQ  per requester: 0 energy, 1 stress, 2 pleasure, 3 invalid.
- req_op  in  2*NUM_REQ  per requester: 0 inc, 1 dec, 2 set, 3 invalid.
- asleep  in  1  creature asleep; selects decay direction for energy.
- ack  out  NUM_REQ  one-cycle acknowledge pulse, one-hot or zero.
- en_inc, en_dec, en_set  out  1 each  energy counter command pulses.
- st_inc, st_dec, st_set  out  1 each  stress counter command pulses.
- pl_inc, pl_dec, pl_set  out  1 each  pleasure counter command pulses.
- cmd_err  out  1  pulse: acked request had an invalid target or op.
- decay_overrun  out  1  sticky; a decay tick arrived while one was still pending.
- busy  out  1  high in the DECAY_A and DECAY_B states.

Behaviour:
- Reset: all outputs 0, state ARB, rr pointer = NUM_REQ-1 (requester 0 wins first), prescaler 0, decay_pending 0.
- All outputs registered.
  - A request sampled at edge N produces its command pulse and ack during the cycle after edge N.
  - Latency 1 cycle.
- Handshake:
  - Requester holds req, req_target and req_op stable until it sees ack.
  - Requester drops req or changes the command on the edge ending the ack cycle.
  - The arbiter masks any requester whose ack is currently high, so a held request is never double-granted.
- Prescaler:
  - Counts 0..DECAY_PERIOD-1 and wraps; counts in every state.
  - On wrap, decay_pending is set.
  - Wrap while decay_pending is already 1: decay_overrun is set and the tick is not queued.
- State ARB:
  - If any unmasked req: grant the first requesting index strictly after the rr pointer, circularly. Update the pointer to the grant.
  - Pulse ack[grant] plus exactly one counter command decoded from target/op.
  - Invalid target or op: ack plus cmd_err, no counter command.
  - If no unmasked req and decay_pending: go to DECAY_A and clear decay_pending.
  - External requests always beat decay; a decay already underway is never preempted.
- State DECAY_A: pulse st_dec, go to DECAY_B.
- State DECAY_B: pulse en_inc if asleep (sampled this cycle), else en_dec. Return to ARB.
- No acks are issued in DECAY_A or DECAY_B. Pending requests wait and retain their rr order.
- Simultaneous prescaler wrap and decay entry: the new tick sets decay_pending with no overrun, because pending was cleared on entry.
- Reset mid-sequence: immediate return to reset values; a partially issued decay is abandoned.
- Never more than one of the nine command outputs high in any cycle (invariant).

Decomposition:
- Package mood_pkg holds:
  - target codes TGT_ENERGY/TGT_STRESS/TGT_PLEASURE/TGT_INVALID;
  - op codes OP_INC/OP_DEC/OP_SET/OP_INVALID;
  - state enum {ARB, DECAY_A, DECAY_B}.
- Sub-module rr_arbiter: combinational masked round-robin pick. Inputs: req vector, mask, pointer. Outputs: one-hot grant, valid.
- Pointer register, FSM, prescaler and command decode stay in mood_cmd_scheduler.

Test Plan:
- Reset release, no req, DECAY_PERIOD=8:
  - st_dec pulses at cycle 9 after reset release, en_dec at cycle 10.
  - busy high in both cycles; sequence repeats every 8 cycles.
- req[0]=req[2]=1 held, both target=stress, op=inc, each dropping after its ack:
  - ack order is 0, then 2 (1 cycle later, thanks to the mask).
  - st_inc pulses twice; never two acks in one cycle.
- All 4 req held permanently (re-requesting after ack):
  - acks rotate 0,1,2,3,0 with exactly one per cycle.
  - decay is deferred and decay_overrun sets after the second wrap.
- req[1] target=3:
  - ack[1] and cmd_err pulse together; all nine counter commands stay 0.
- asleep=1 during decay:
  - DECAY_B emits en_inc, not en_dec.
  - req[0] raised during DECAY_A is acked in the cycle after DECAY_B.
- rst asserted asynchronously in DECAY_A:
  - outputs are 0 within the same cycle, with no en_dec afterwards.
  - after release, requester 0 is granted first.
